// File: rtl/decode_stage.sv
// RV32I decode stage: registered control/operand bundle with
// load-use bubble insertion and branch flush.
module decode_stage #(
   parameter int XLEN      = 32,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_funct3,
   output logic [3:0]       out_alu_op,
   output logic [1:0]       out_alu_src,
   output logic [1:0]       out_branch_sel,
   output logic             out_mr,
   output logic             out_mtr,
   output logic             out_mw,
   output logic             out_rw,
   output logic             out_illegal,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASB = 4'd10;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2, rd;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   logic s;
   assign s = in_instr[31];

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign imm_i = {{(XLEN-12){s}}, in_instr[31:20]};
   assign imm_s = {{(XLEN-12){s}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{(XLEN-12){s}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){s}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
   // Shift immediates carry only the shift amount (6 bits on RV64).
   assign imm_sh = (XLEN == 64) ?
                   {{(XLEN-6){1'b0}}, in_instr[25:20]} :
                   {{(XLEN-5){1'b0}}, in_instr[24:20]};

   function automatic logic [3:0] f3_op(input logic [2:0] f,
                                        input logic alt,
                                        input logic sub_ok);
      logic [3:0] op;
      unique case (f)
         3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [3:0]      d_alu_op;
   logic [1:0]      d_alu_src, d_br;
   logic            d_mr, d_mtr, d_mw, d_rw, d_ill;
   logic            use_rs1, use_rs2;
   logic [XLEN-1:0] d_imm;

   // Decode the incoming instruction into its control bundle.
   always_comb begin
      d_alu_op  = ALU_ADD;
      d_alu_src = 2'd0;
      d_br      = 2'd0;
      d_mr      = 1'b0;
      d_mtr     = 1'b0;
      d_mw      = 1'b0;
      d_rw      = 1'b0;
      d_ill     = 1'b0;
      d_imm     = '0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      unique case (opcode)
         OP_R: begin
            d_alu_op = f3_op(funct3, in_instr[30], 1'b1);
            d_rw     = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            d_ill    = !((funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) &&
                          ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OP_I: begin
            d_alu_op  = f3_op(funct3, in_instr[30], 1'b0);
            d_alu_src = 2'd1;
            d_rw      = 1'b1;
            use_rs1   = 1'b1;
            d_imm     = (funct3[1:0] == 2'b01) ? imm_sh : imm_i;
         end
         OP_LOAD: begin
            d_alu_src = 2'd1;
            d_mr      = 1'b1;
            d_mtr     = 1'b1;
            d_rw      = 1'b1;
            use_rs1   = 1'b1;
            d_imm     = imm_i;
         end
         OP_STORE: begin
            d_alu_src = 2'd1;
            d_mw      = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            d_imm     = imm_s;
         end
         OP_BR: begin
            d_alu_op = ALU_SUB;
            d_br     = 2'd1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            d_imm    = imm_b;
         end
         OP_JAL: begin
            d_br  = 2'd2;
            d_rw  = 1'b1;
            d_imm = imm_j;
         end
         OP_JALR: begin
            d_br      = 2'd3;
            d_alu_src = 2'd1;
            d_rw      = 1'b1;
            use_rs1   = 1'b1;
            d_imm     = imm_i;
         end
         OP_LUI: begin
            d_alu_op  = ALU_PASB;
            d_alu_src = 2'd1;
            d_rw      = 1'b1;
            d_imm     = imm_u;
         end
         OP_AUIPC: begin
            d_alu_src = 2'd2;
            d_rw      = 1'b1;
            d_imm     = imm_u;
         end
         default: d_ill = 1'b1;
      endcase
      if (rd == 5'd0) d_rw = 1'b0;
   end

   logic hazard, advance;

   assign hazard = HAZARD_EN && out_valid && out_mr &&
                   (out_rd != 5'd0) && in_valid &&
                   ((use_rs1 && (rs1 == out_rd)) ||
                    (use_rs2 && (rs2 == out_rd)));
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush;

   // Bundle register: flush, accept, bubble, drain or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_pc         <= '0;
         out_rs1        <= '0;
         out_rs2        <= '0;
         out_rd         <= '0;
         out_imm        <= '0;
         out_funct3     <= '0;
         out_alu_op     <= '0;
         out_alu_src    <= '0;
         out_branch_sel <= '0;
         out_mr         <= 1'b0;
         out_mtr        <= 1'b0;
         out_mw         <= 1'b0;
         out_rw         <= 1'b0;
         out_illegal    <= 1'b0;
         bubble_cnt     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         if (in_valid && !hazard) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_rs1        <= rs1;
            out_rs2        <= rs2;
            out_rd         <= rd;
            out_imm        <= d_imm;
            out_funct3     <= funct3;
            out_alu_op     <= d_alu_op;
            out_alu_src    <= d_alu_src;
            out_branch_sel <= d_br;
            out_mr         <= d_mr;
            out_mtr        <= d_mtr;
            out_mw         <= d_mw;
            out_rw         <= d_rw;
            out_illegal    <= d_ill;
         end else begin
            out_valid <= 1'b0;
            if (hazard && (bubble_cnt != '1))
               bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

endmodule
